data_mem_unit: RTL
==================

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter ADDR_W, default 16: byte-address width.
REQ-003 Parameter DEPTH_BYTES, default 256: storage size in bytes; SHALL be a power of 2 and a multiple of DATA_W/8.
REQ-004 Port C, input, 1: clock, rising-edge active.
REQ-005 Port R, input, 1: reset, asynchronous, active-high.
REQ-006 Ports req_valid in 1, req_ready out 1: request handshake; the request is accepted on a rising edge of C with both high.
REQ-007 Port op, input, 3: 000 NOP, 001 LB (sign-extend), 010 LBU (zero-extend), 011 LW, 100 SB, 101 SW, 110/111 reserved.
REQ-008 Port addr, input, ADDR_W: byte address, little-endian.
REQ-009 Port wdata, input, DATA_W: store data; SB uses bits [7:0].
REQ-010 Ports rsp_valid out 1, rsp_ready in 1: response handshake; the response is consumed on a rising edge of C with both high.
REQ-011 Port rdata, output, DATA_W: load result; 0 for stores and errors.
REQ-012 Port err, output, 1: error flag, qualified by rsp_valid.

Function
REQ-013 FSM states: IDLE and RESP; req_ready SHALL equal (state==IDLE).
REQ-014 IDLE to RESP: on acceptance of op 001-101; rdata, err and rsp_valid are registered on that edge, giving one-cycle latency.
REQ-015 Ops 000/110/111 are accepted, have no effect and produce no response; the state stays IDLE.
REQ-016 RESP to IDLE: on rsp_ready; rsp_valid, rdata and err SHALL hold stable until then.
REQ-017 Stores commit on the accepting edge; a load issued right after a store SHALL return the new data.
REQ-018 Effective address = addr mod DEPTH_BYTES (wrap-around); no out-of-range error.
REQ-019 Word access covers bytes ea..ea+DATA_W/8-1; byte ea lands in rdata[7:0].
REQ-020 LB replicates bit 7 into bits [DATA_W-1:8]; LBU zero-fills them.
REQ-021 SB writes one byte; SW writes DATA_W/8 bytes; other bytes are unchanged.

Reset
REQ-022 While R is high: state=IDLE, req_ready=0, rsp_valid=0, rdata=0, err=0, and no store occurs; storage contents are not cleared.
REQ-023 Asserting R while in RESP SHALL drop the pending response; after release, req_ready=1 on the first edge.

Configuration
REQ-024 Macro DATA_MEM_MISALIGN_TRAP_EN.
- Defined: an LW/SW whose ea is not a multiple of DATA_W/8 SHALL not write, SHALL return rdata=0 and err=1.
- Undefined: the low log2(DATA_W/8) bits of ea are forced to 0 for LW/SW, and err is tied to 0.

Structure
REQ-025 Package data_mem_pkg SHALL hold the op encodings (enum), the FSM state type, and the NB=DATA_W/8 helper function.
REQ-026 Sub-module mem_byte_bank SHALL provide the storage: a DEPTH_BYTES x 8 array with per-byte write enables and an NB-byte read port.

Verification (DATA_W=16, DEPTH_BYTES=256)
REQ-027 SW addr 0x0006 wdata 0x000A, then LW addr 0x0006 -> rsp rdata 0x000A, err 0, rsp_valid one cycle after acceptance.
REQ-028 SB addr 0x0000 wdata 0x8F, then LB 0x0000 -> 0xFF8F; LBU 0x0000 -> 0x008F.
REQ-029 SW 0x0106 wdata 0x1234, then LW 0x0006 -> 0x1234 (wrap); LB 0x0007 -> 0x0012.
REQ-030 LW 0x0007 -> with macro: err 1, rdata 0, memory unchanged; without macro: data at 0x0006, err 0.
REQ-031 rsp_ready held low 5 cycles -> rsp_valid/rdata stable and req_ready 0 throughout; req_ready 1 the cycle after rsp_ready.
REQ-032 R pulsed while in RESP -> rsp_valid 0 immediately (asynchronous); stored data is retained on a subsequent LW.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types for the data memory unit: op encodings, FSM state type and
// the bytes-per-word helper.
package data_mem_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LB   = 3'b001,
    OP_LBU  = 3'b010,
    OP_LW   = 3'b011,
    OP_SB   = 3'b100,
    OP_SW   = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Bytes per data word.
  function automatic int nb(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/data_mem_unit_bank.sv
// Byte-organised storage: DEPTH_BYTES x 8 array, per-byte write enables and
// an NB-byte read port. Lane i addresses byte (addr + i) modulo the depth, so
// word accesses wrap naturally at the top of the array. Contents are never
// reset.
module mem_byte_bank #(
  parameter int DEPTH_BYTES = 256,
  parameter int NB          = 2
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_BYTES)-1:0] addr,
  input  logic [NB-1:0]                  we,
  input  logic [NB*8-1:0]                wdata,
  output logic [NB*8-1:0]                rdata
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] lane_addr [NB];

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign lane_addr[i]      = addr + AW'(i);
    assign rdata[i*8 +: 8]   = mem[lane_addr[i]];
  end

  // Per-lane byte writes on the rising edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem[lane_addr[i]] <= wdata[i*8 +: 8];
    end
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data memory unit: single-request/single-response byte-addressed memory with
// LB/LBU/LW/SB/SW. One-cycle response latency, response held until consumed.
// Optional macro DATA_MEM_MISALIGN_TRAP_EN: misaligned LW/SW report err and do
// nothing; without it, the word offset bits are cleared and err stays 0.
module data_mem_unit
  import data_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_BYTES = 256
) (
  input  logic              C,
  input  logic              R,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int NB   = nb(DATA_W);
  localparam int AW_M = $clog2(DEPTH_BYTES);
  localparam logic [AW_M-1:0] LOW_MASK = AW_M'(NB - 1);

  state_e            state;
  op_e               op_c;
  logic              word_op;
  logic              misalign;
  logic              accept;
  logic              rsp_op;
  logic [AW_M-1:0]   ea_raw;
  logic [AW_M-1:0]   ea;
  logic [NB-1:0]     we;
  logic [DATA_W-1:0] bank_rd;
  logic [DATA_W-1:0] rdata_n;
  logic              err_n;
  logic              addr_unused;

  // Address bits above the storage size are ignored (wrap-around).
  assign addr_unused = &{1'b0, addr[ADDR_W-1:AW_M]};

  mem_byte_bank #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .NB          (NB)
  ) u_bank (
    .clk   (C),
    .addr  (ea),
    .we    (we),
    .wdata (wdata),
    .rdata (bank_rd)
  );

  // Decode: effective address, write enables and next response values.
  always_comb begin
    op_c    = op_e'(op);
    word_op = (op_c == OP_LW) || (op_c == OP_SW);
    ea_raw  = addr[AW_M-1:0];
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    misalign = word_op && ((ea_raw & LOW_MASK) != '0);
    ea       = ea_raw;
`else
    misalign = 1'b0;
    ea       = word_op ? (ea_raw & ~LOW_MASK) : ea_raw;
`endif
    accept  = req_valid && req_ready;
    rsp_op  = 1'b0;
    we      = '0;
    rdata_n = '0;
    err_n   = 1'b0;
    case (op_c)
      OP_LB: begin
        rsp_op  = 1'b1;
        rdata_n = {{(DATA_W-8){bank_rd[7]}}, bank_rd[7:0]};
      end
      OP_LBU: begin
        rsp_op  = 1'b1;
        rdata_n = {{(DATA_W-8){1'b0}}, bank_rd[7:0]};
      end
      OP_LW: begin
        rsp_op  = 1'b1;
        rdata_n = misalign ? '0 : bank_rd;
        err_n   = misalign;
      end
      OP_SB: begin
        rsp_op = 1'b1;
        if (accept) we = NB'(1);
      end
      OP_SW: begin
        rsp_op = 1'b1;
        err_n  = misalign;
        if (accept && !misalign) we = '1;
      end
      default: rsp_op = 1'b0;
    endcase
  end

  // Request/response FSM with registered handshake outputs. req_ready comes
  // out of reset low and rises on the first edge after release.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept && rsp_op) begin
            state     <= ST_RESP;
            req_ready <= 1'b0;
            rsp_valid <= 1'b1;
            rdata     <= rdata_n;
            err       <= err_n;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
